pkt_prio_queue: RTL and testbench
=================================

# pkt_prio_queue

Priority buffer directly downstream of the packet priority calculator. Accepts `{data, priority}` pairs from the calculator's `out_valid/out_data/out_prior` outputs and holds up to QUEUE_SIZE entries. On request, it releases the entry with the numerically smallest priority; equal priorities leave in arrival order. It is the scheduling stage between priority calculation and the egress datapath.

## Interface
Parameters:
- DWIDTH, 32, payload width; matches the calculator.
- PRIOR_WIDTH, 6, priority width; matches the calculator.
- QUEUE_SIZE, 16, entry count; power of two, ≥2.
- CNT_WIDTH, 16, drop counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  insert request; driven by the calculator's out_valid
- in_data  in  DWIDTH  payload
- in_prior  in  PRIOR_WIDTH  priority; smaller value is served first
- in_ready  out  1  insert will be accepted this cycle
- deq_en  in  1  dequeue request
- deq_valid  out  1  deq_data/deq_prior valid this cycle (1-cycle pulse)
- deq_data  out  DWIDTH  dequeued payload
- deq_prior  out  PRIOR_WIDTH  dequeued priority
- count  out  $clog2(QUEUE_SIZE)+1  occupied entries
- full  out  1  count == QUEUE_SIZE
- empty  out  1  count == 0
- drop_cnt  out  CNT_WIDTH  inserts refused while not ready; saturating

## Operation
- Storage: QUEUE_SIZE entries, each `{valid, prior, data, ord}`. `ord` ($clog2(QUEUE_SIZE) bits) is the arrival rank among valid entries: 0 is oldest.
- Selection (combinational): among valid entries, pick the one with the smallest `prior`. Break ties with the smallest `ord`.
- Dequeue:
  - Fires when `deq_en && !empty`.
  - The selected entry is copied to the deq_* registers and deq_valid is set. The entry is invalidated.
  - Every valid entry with `ord` greater than the removed one decrements its `ord`.
- Insert:
  - Fires when `in_valid && in_ready`.
  - `in_ready = !full || (deq_en && !empty)`.
  - The entry is written into the lowest-index free slot, with `ord` = post-dequeue count.
  - When full with a simultaneous dequeue, the write goes into the slot freed by that dequeue.
- Drop: when `in_valid && !in_ready`, drop_cnt increments (saturating at all-ones) and the data is discarded. The upstream stage has no backpressure, so nothing is retried.
- Simultaneous insert and dequeue: count is unchanged. The new entry cannot be the one dequeued in the same cycle.
- `deq_en` while empty: ignored; deq_valid = 0.
- `deq_data`/`deq_prior` hold their last value while deq_valid = 0.

## Timing
- Reset (rst high at a clk edge) clears:
  - all valid bits and ord fields;
  - deq_valid = 0, deq_data = 0, deq_prior = 0;
  - count = 0, drop_cnt = 0.
- Reset values seen on outputs after reset: full = 0, empty = 1, in_ready = 1.
- Reset mid-operation discards all entries. No output pulse follows.
- Insert latency: an entry accepted at edge N is dequeue-eligible from cycle N+1.
- Dequeue latency: deq_en sampled at edge N gives deq_valid high during cycle N+1. Back-to-back deq_en gives one result per cycle.
- count, full, empty and drop_cnt are registered and update at the same edge as the insert or dequeue.
- in_ready is combinational from full, deq_en and empty.
- Selection is a single-cycle combinational compare over QUEUE_SIZE entries. No pipelining is required at the defaults.

## Structure
- Add to pkt_h:
  - typedef `PqEntry` = `{valid, prior[PRIOR_WIDTH], ord, data[DWIDTH]}`, packed;
  - a localparam for the default QUEUE_SIZE.
- Sub-module `pkt_pq_argmin`:
  - parameterised, combinational;
  - inputs: entry valid/prior/ord vectors;
  - outputs: selected index and found flag;
  - built as a binary compare tree.
- The top level holds the entry array, the count, the drop counter and the output registers.

## Test plan
- Reset then priority order:
  - Insert priorities 5, 2, 9, 2 with data A, B, C, D, one per cycle.
  - Issue four deq_en.
  - Expect out B(2), D(2), A(5), C(9). Expect count 4→0 and empty = 1.
- Full and drop:
  - Insert 16 entries; expect full = 1.
  - Insert a 17th; expect in_ready = 0, drop_cnt = 1 and count stays 16.
- Full with simultaneous insert and dequeue:
  - With 16 entries, assert in_valid (prior 0, data E) with deq_en.
  - Expect the previous minimum to be dequeued, count = 16 and drop_cnt unchanged.
  - Expect the next deq_en to return E.
- Empty dequeue: deq_en with empty = 1 → deq_valid stays 0 and deq_data keeps its last value.
- Reset mid-operation:
  - With 7 entries, assert rst for one cycle.
  - Expect count = 0, empty = 1, deq_valid = 0 and drop_cnt = 0.
  - Expect a following deq_en to produce nothing.
- drop_cnt saturation (CNT_WIDTH = 2 override): full queue with 5 refused inserts → drop_cnt = 3.

Source files
------------

// File: rtl/pkt_h.sv
// Shared definitions for the packet priority path: default sizes and the
// packed layout of one priority-queue entry.
package pkt_h;

  localparam int PQ_DEF_DWIDTH      = 32;
  localparam int PQ_DEF_PRIOR_WIDTH = 6;
  localparam int PQ_DEF_QUEUE_SIZE  = 16;
  localparam int PQ_DEF_CNT_WIDTH   = 16;
  localparam int PQ_DEF_ORD_WIDTH   = $clog2(PQ_DEF_QUEUE_SIZE);

  // One queue slot at the default sizes; ord is the arrival rank (0 = oldest).
  typedef struct packed {
    logic                          valid;
    logic [PQ_DEF_PRIOR_WIDTH-1:0] prior;
    logic [PQ_DEF_ORD_WIDTH-1:0]   ord;
    logic [PQ_DEF_DWIDTH-1:0]      data;
  } PqEntry;

endpackage

// File: rtl/pkt_pq_argmin.sv
// Combinational binary compare tree: finds the valid entry with the smallest
// priority, ties broken by the smallest arrival rank.
module pkt_pq_argmin #(
  parameter int N  = 16,
  parameter int PW = 6,
  parameter int OW = $clog2(N),
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]    valid_i,
  input  logic [N*PW-1:0] prior_i,
  input  logic [N*OW-1:0] ord_i,
  output logic [IW-1:0]   idx_o,
  output logic            found_o
);

  localparam int LG = $clog2(N);

  // Level 0 holds the leaves; each higher level halves the candidate count.
  for (genvar l = 0; l <= LG; l++) begin : lvl
    localparam int M = N >> l;
    logic [M-1:0]  v;
    logic [PW-1:0] p [M];
    logic [OW-1:0] o [M];
    logic [IW-1:0] x [M];

    if (l == 0) begin : leaf
      for (genvar i = 0; i < M; i++) begin : g
        assign v[i] = valid_i[i];
        assign p[i] = prior_i[i*PW +: PW];
        assign o[i] = ord_i[i*OW +: OW];
        assign x[i] = IW'(i);
      end
    end else begin : node
      for (genvar i = 0; i < M; i++) begin : g
        logic take_l;
        // Left wins if it is valid and the right is absent or strictly worse.
        assign take_l = lvl[l-1].v[2*i] &&
                        (!lvl[l-1].v[2*i+1] ||
                         (lvl[l-1].p[2*i] < lvl[l-1].p[2*i+1]) ||
                         ((lvl[l-1].p[2*i] == lvl[l-1].p[2*i+1]) &&
                          (lvl[l-1].o[2*i] < lvl[l-1].o[2*i+1])));
        assign v[i] = lvl[l-1].v[2*i] | lvl[l-1].v[2*i+1];
        assign p[i] = take_l ? lvl[l-1].p[2*i] : lvl[l-1].p[2*i+1];
        assign o[i] = take_l ? lvl[l-1].o[2*i] : lvl[l-1].o[2*i+1];
        assign x[i] = take_l ? lvl[l-1].x[2*i] : lvl[l-1].x[2*i+1];
      end
    end
  end

  assign idx_o   = lvl[LG].x[0];
  assign found_o = lvl[LG].v[0];

endmodule

// File: rtl/pkt_prio_queue.sv
// Priority buffer between the priority calculator and egress. Holds up to
// QUEUE_SIZE {data, priority} entries and releases the smallest priority first,
// equal priorities in arrival order. Inserts arriving while not ready are
// dropped and counted (no upstream backpressure exists).
// Handshake: an insert is taken on any edge where in_valid && in_ready; a
// dequeue fires on any edge where deq_en && !empty and its result is shown
// for exactly one cycle with deq_valid.
module pkt_prio_queue
  import pkt_h::*;
#(
  parameter int DWIDTH      = PQ_DEF_DWIDTH,
  parameter int PRIOR_WIDTH = PQ_DEF_PRIOR_WIDTH,
  parameter int QUEUE_SIZE  = PQ_DEF_QUEUE_SIZE,
  parameter int CNT_WIDTH   = PQ_DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic [PRIOR_WIDTH-1:0]        in_prior,
  output logic                          in_ready,
  input  logic                          deq_en,
  output logic                          deq_valid,
  output logic [DWIDTH-1:0]             deq_data,
  output logic [PRIOR_WIDTH-1:0]        deq_prior,
  output logic [$clog2(QUEUE_SIZE):0]   count,
  output logic                          full,
  output logic                          empty,
  output logic [CNT_WIDTH-1:0]          drop_cnt
);

  localparam int IW = $clog2(QUEUE_SIZE);
  localparam int CW = IW + 1;

  // Same field order as pkt_h::PqEntry, sized by this instance's parameters.
  typedef struct packed {
    logic                   valid;
    logic [PRIOR_WIDTH-1:0] prior;
    logic [IW-1:0]          ord;
    logic [DWIDTH-1:0]      data;
  } entry_t;

  entry_t                 ent_q [QUEUE_SIZE];
  entry_t                 ent_d [QUEUE_SIZE];
  logic [CW-1:0]          count_q, count_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic                   deq_valid_q, deq_valid_d;
  logic [DWIDTH-1:0]      deq_data_q, deq_data_d;
  logic [PRIOR_WIDTH-1:0] deq_prior_q, deq_prior_d;

  logic [QUEUE_SIZE-1:0]             vld_vec;
  logic [QUEUE_SIZE*PRIOR_WIDTH-1:0] prior_flat;
  logic [QUEUE_SIZE*IW-1:0]          ord_flat;
  logic [IW-1:0]                     sel_idx;
  logic                              sel_found;
  entry_t                            sel_e;

  logic          full_w, empty_w, deq_fire, ins_fire;
  logic [IW-1:0] free_idx, wr_idx, ord_new;
  logic          free_found;

  // Flatten the entry array into the vectors the compare tree consumes.
  always_comb begin
    vld_vec    = '0;
    prior_flat = '0;
    ord_flat   = '0;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      vld_vec[i]                          = ent_q[i].valid;
      prior_flat[i*PRIOR_WIDTH +: PRIOR_WIDTH] = ent_q[i].prior;
      ord_flat[i*IW +: IW]                = ent_q[i].ord;
    end
  end

  pkt_pq_argmin #(
    .N  (QUEUE_SIZE),
    .PW (PRIOR_WIDTH),
    .OW (IW),
    .IW (IW)
  ) u_argmin (
    .valid_i (vld_vec),
    .prior_i (prior_flat),
    .ord_i   (ord_flat),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  assign sel_e    = ent_q[sel_idx];
  assign full_w   = (count_q == CW'(QUEUE_SIZE));
  assign empty_w  = (count_q == '0);
  assign deq_fire = deq_en && !empty_w && sel_found;
  assign in_ready = !full_w || deq_fire;
  assign ins_fire = in_valid && in_ready;
  // New arrival is ranked after every entry that survives this cycle.
  assign ord_new  = IW'(count_q - CW'(deq_fire));

  // Lowest-index free slot; when full, the slot vacated by this dequeue.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        free_idx   = IW'(i);
        free_found = 1'b1;
      end
    end
    wr_idx = free_found ? free_idx : sel_idx;
  end

  // Next-state for entries, occupancy, drop counter and dequeue outputs.
  always_comb begin
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      ent_d[i] = ent_q[i];
    end
    count_d     = count_q;
    drop_d      = drop_q;
    deq_valid_d = 1'b0;
    deq_data_d  = deq_data_q;
    deq_prior_d = deq_prior_q;

    if (deq_fire) begin
      deq_valid_d = 1'b1;
      deq_data_d  = sel_e.data;
      deq_prior_d = sel_e.prior;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (IW'(i) == sel_idx) begin
          ent_d[i].valid = 1'b0;
        end else if (ent_q[i].valid && (ent_q[i].ord > sel_e.ord)) begin
          ent_d[i].ord = ent_q[i].ord - 1'b1;
        end
      end
    end

    if (ins_fire) begin
      ent_d[wr_idx].valid = 1'b1;
      ent_d[wr_idx].prior = in_prior;
      ent_d[wr_idx].ord   = ord_new;
      ent_d[wr_idx].data  = in_data;
    end

    if (ins_fire && !deq_fire) begin
      count_d = count_q + 1'b1;
    end else if (!ins_fire && deq_fire) begin
      count_d = count_q - 1'b1;
    end

    if (in_valid && !in_ready && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        ent_q[i] <= '0;
      end
      count_q     <= '0;
      drop_q      <= '0;
      deq_valid_q <= 1'b0;
      deq_data_q  <= '0;
      deq_prior_q <= '0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q     <= count_d;
      drop_q      <= drop_d;
      deq_valid_q <= deq_valid_d;
      deq_data_q  <= deq_data_d;
      deq_prior_q <= deq_prior_d;
    end
  end

  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign drop_cnt  = drop_q;
  assign deq_valid = deq_valid_q;
  assign deq_data  = deq_data_q;
  assign deq_prior = deq_prior_q;

endmodule

// File: tb/tb_pkt_prio_queue.sv
// Directed bench for pkt_prio_queue, built with a 2-bit drop counter so that
// saturation is reachable.
module tb_pkt_prio_queue;

  localparam int DW = 32;
  localparam int PW = 6;
  localparam int QS = 16;
  localparam int CNTW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [PW-1:0] in_prior;
  logic          in_ready;
  logic          deq_en;
  logic          deq_valid;
  logic [DW-1:0] deq_data;
  logic [PW-1:0] deq_prior;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic [CNTW-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  pkt_prio_queue #(
    .DWIDTH      (DW),
    .PRIOR_WIDTH (PW),
    .QUEUE_SIZE  (QS),
    .CNT_WIDTH   (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_prior  (in_prior),
    .in_ready  (in_ready),
    .deq_en    (deq_en),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_prior (deq_prior),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (drop_cnt)
  );

  // Advance one edge and settle 1 ns past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ins(input logic [PW-1:0] p, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_prior = p;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_prior = '0; deq_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_deq_data", deq_data, 0);
    chk("rst_deq_prior", deq_prior, 0);
    chk("rst_drop", drop_cnt, 0);

    // Priority order with a tie: 5A 2B 9C 2D -> B D A C
    ins(6'd5, 32'hA);
    ins(6'd2, 32'hB);
    ins(6'd9, 32'hC);
    ins(6'd2, 32'hD);
    chk("t1_count4", count, 4);
    deq_en = 1'b1;
    tick();
    chk("t1_v0", deq_valid, 1); chk("t1_d0", deq_data, 32'hB); chk("t1_p0", deq_prior, 2);
    chk("t1_c3", count, 3);
    tick();
    chk("t1_v1", deq_valid, 1); chk("t1_d1", deq_data, 32'hD); chk("t1_p1", deq_prior, 2);
    chk("t1_c2", count, 2);
    tick();
    chk("t1_d2", deq_data, 32'hA); chk("t1_p2", deq_prior, 5);
    chk("t1_c1", count, 1);
    tick();
    chk("t1_d3", deq_data, 32'hC); chk("t1_p3", deq_prior, 9);
    chk("t1_c0", count, 0);
    deq_en = 1'b0;
    tick();
    chk("t1_valid_drop", deq_valid, 0);
    chk("t1_empty", empty, 1);

    // Fill to 16 with priorities 10..25, then one refused insert
    for (int i = 0; i < QS; i++) ins(PW'(10 + i), 32'h100 + i);
    chk("t2_full", full, 1);
    chk("t2_count16", count, 16);
    chk("t2_not_ready", in_ready, 0);
    ins(6'd1, 32'hBAD);
    chk("t2_drop1", drop_cnt, 1);
    chk("t2_count_kept", count, 16);

    // Full with simultaneous insert (prior 0, E) and dequeue
    in_valid = 1'b1; in_prior = 6'd0; in_data = 32'hEEEE; deq_en = 1'b1;
    #1;
    chk("t3_ready_full_deq", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("t3_v", deq_valid, 1);
    chk("t3_d", deq_data, 32'h100);
    chk("t3_p", deq_prior, 10);
    chk("t3_count", count, 16);
    chk("t3_drop", drop_cnt, 1);
    tick();
    chk("t3_e_data", deq_data, 32'hEEEE);
    chk("t3_e_prior", deq_prior, 0);
    chk("t3_count15", count, 15);

    // Drain the rest in priority order 11..25
    for (int k = 1; k < QS; k++) begin
      tick();
      chk("drain_v", deq_valid, 1);
      chk("drain_d", deq_data, 32'h100 + k);
      chk("drain_p", deq_prior, 10 + k);
    end

    // Empty dequeue: nothing fires and data holds
    tick();
    chk("t4_no_valid", deq_valid, 0);
    chk("t4_hold_data", deq_data, 32'h10F);
    chk("t4_hold_prior", deq_prior, 25);
    chk("t4_empty", empty, 1);
    deq_en = 1'b0;

    // Reset mid-operation with 7 entries
    for (int i = 0; i < 7; i++) ins(PW'(3 + i), 32'h200 + i);
    chk("t5_count7", count, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_count0", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_deq_valid", deq_valid, 0);
    chk("t5_drop0", drop_cnt, 0);
    chk("t5_data0", deq_data, 0);
    deq_en = 1'b1;
    tick();
    deq_en = 1'b0;
    chk("t5_deq_nothing", deq_valid, 0);
    tick();
    chk("t5_still_nothing", deq_valid, 0);

    // Drop counter saturation: 5 refused inserts into a full queue
    for (int i = 0; i < QS; i++) ins(PW'(i), 32'h300 + i);
    chk("t6_full", full, 1);
    in_valid = 1'b1; in_prior = 6'd0; in_data = 32'hDEAD;
    tick(); tick();
    chk("t6_drop2", drop_cnt, 2);
    tick(); tick(); tick();
    in_valid = 1'b0;
    chk("t6_drop_sat", drop_cnt, 3);
    chk("t6_count16", count, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
